exception_unit: RTL and testbench

//  Machine-mode trap and CSR block sitting in the MEM stage, downstream of the decode control unit.

---
 rtl/exception_unit.sv | 199 +++++++++++++++++++
 tb/tb_exception_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/exception_unit.sv
// exception_unit: machine-mode trap and CSR block in the MEM stage.
// It holds mstatus (MIE/MPIE), mtvec, mepc, mcause and mtval. It handles
// CSR read/modify/write and MRET, and runs a two-cycle trap entry:
//   IDLE  : trap detected, pipeline flushed, mepc and mstatus updated
//   CAUSE : mcause/mtval committed, fetch redirected to mtvec
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   exp_vector, mret        decoded {illegal, ecall} and MRET for the MEM instruction
//   l/s_access_fault        memory faults; interrupt is the level machine external IRQ
//   epc_cur, epc_next       trapping PC / interrupt return PC
//   fault_addr, inst_mem    trap value sources
//   csr_*                   CSR access controls and write sources
//   csr_r_data_out          old CSR value for rd
//   PC_redirect, redirect_mux, reg_*_flush, RegWrite_cancel  pipeline control
module exception_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      exp_vector,
  input  logic            mret,
  input  logic            l_access_fault,
  input  logic            s_access_fault,
  input  logic            interrupt,
  input  logic [XLEN-1:0] epc_cur,
  input  logic [XLEN-1:0] epc_next,
  input  logic [XLEN-1:0] fault_addr,
  input  logic [XLEN-1:0] inst_mem,
  input  logic            csr_rw,
  input  logic [11:0]     csr_rw_addr,
  input  logic [1:0]      csr_wsc_mode,
  input  logic            csr_w_imm_mux,
  input  logic [XLEN-1:0] csr_w_data_reg,
  input  logic [4:0]      csr_w_data_imm,
  output logic [XLEN-1:0] csr_r_data_out,
  output logic [XLEN-1:0] PC_redirect,
  output logic            redirect_mux,
  output logic            reg_FD_flush,
  output logic            reg_DE_flush,
  output logic            reg_EM_flush,
  output logic            reg_MW_flush,
  output logic            RegWrite_cancel
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic {IDLE, CAUSE} state_t;

  state_t          state_q, state_d;
  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] cause_q, cause_d, tval_q, tval_d;

  logic            is_idle, irq, trap, is_irq;
  logic [XLEN-1:0] trap_cause, trap_tval;
  logic [XLEN-1:0] csr_old, csr_src, csr_new;

  always_comb begin
    state_d  = state_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    cause_d  = cause_q;
    tval_d   = tval_q;

    csr_r_data_out  = '0;
    PC_redirect     = '0;
    redirect_mux    = 1'b0;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    reg_EM_flush    = 1'b0;
    reg_MW_flush    = 1'b0;
    RegWrite_cancel = 1'b0;

    is_idle = (state_q == IDLE);
    irq     = interrupt & mie_q;
    trap    = is_idle & (exp_vector[1] | exp_vector[0] | l_access_fault |
                         s_access_fault | irq);

    // Priority order: illegal, ecall, load fault, store fault, interrupt.
    is_irq     = 1'b0;
    trap_cause = '0;
    trap_tval  = '0;
    if (exp_vector[1]) begin
      trap_cause = XLEN'(2);
      trap_tval  = inst_mem;
    end else if (exp_vector[0]) begin
      trap_cause = XLEN'(11);
    end else if (l_access_fault) begin
      trap_cause = XLEN'(5);
      trap_tval  = fault_addr;
    end else if (s_access_fault) begin
      trap_cause = XLEN'(7);
      trap_tval  = fault_addr;
    end else if (irq) begin
      is_irq     = 1'b1;
      trap_cause = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
    end

    unique case (csr_rw_addr)
      ADDR_MSTATUS: csr_old = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mie_q, 3'b000};
      ADDR_MTVEC:   csr_old = mtvec_q;
      ADDR_MEPC:    csr_old = mepc_q;
      ADDR_MCAUSE:  csr_old = mcause_q;
      ADDR_MTVAL:   csr_old = mtval_q;
      default:      csr_old = '0;
    endcase

    csr_src = csr_w_imm_mux ? {{(XLEN-5){1'b0}}, csr_w_data_imm} : csr_w_data_reg;
    unique case (csr_wsc_mode)
      2'b01:   csr_new = csr_src;
      2'b10:   csr_new = csr_old | csr_src;
      2'b11:   csr_new = csr_old & ~csr_src;
      default: csr_new = csr_old;
    endcase

    if (trap) begin
      reg_FD_flush    = 1'b1;
      reg_DE_flush    = 1'b1;
      reg_EM_flush    = 1'b1;
      reg_MW_flush    = 1'b1;
      RegWrite_cancel = 1'b1;
      mepc_d  = is_irq ? epc_next : epc_cur;
      mpie_d  = mie_q;
      mie_d   = 1'b0;
      cause_d = trap_cause;
      tval_d  = trap_tval;
      state_d = CAUSE;
    end else if (is_idle) begin
      if (csr_rw) begin
        csr_r_data_out = csr_old;
        if (csr_wsc_mode != 2'b00) begin
          unique case (csr_rw_addr)
            ADDR_MSTATUS: begin
              mie_d  = csr_new[3];
              mpie_d = csr_new[7];
            end
            ADDR_MTVEC:  mtvec_d  = {csr_new[XLEN-1:2], 2'b00};
            ADDR_MEPC:   mepc_d   = csr_new;
            ADDR_MCAUSE: mcause_d = csr_new;
            ADDR_MTVAL:  mtval_d  = csr_new;
            default: ;
          endcase
        end
      end
      // MRET's mstatus update takes effect over a same-cycle mstatus write.
      if (mret) begin
        redirect_mux = 1'b1;
        PC_redirect  = mepc_q;
        reg_FD_flush = 1'b1;
        reg_DE_flush = 1'b1;
        mie_d        = mpie_q;
        mpie_d       = 1'b1;
      end
    end else begin
      // CAUSE: commit the latched cause/tval and jump to the handler.
      mcause_d     = cause_q;
      mtval_d      = tval_q;
      redirect_mux = 1'b1;
      PC_redirect  = mtvec_q;
      reg_FD_flush = 1'b1;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
    end else begin
      state_q  <= state_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
module tb_exception_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  exp_vector;
  logic        mret, l_access_fault, s_access_fault, interrupt;
  logic [31:0] epc_cur, epc_next, fault_addr, inst_mem;
  logic        csr_rw;
  logic [11:0] csr_rw_addr;
  logic [1:0]  csr_wsc_mode;
  logic        csr_w_imm_mux;
  logic [31:0] csr_w_data_reg;
  logic [4:0]  csr_w_data_imm;
  logic [31:0] csr_r_data_out, PC_redirect;
  logic        redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
  logic        RegWrite_cancel;

  int checks = 0;
  int errors = 0;

  exception_unit #(.XLEN(32), .MTVEC_RST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .exp_vector(exp_vector), .mret(mret),
    .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
    .interrupt(interrupt), .epc_cur(epc_cur), .epc_next(epc_next),
    .fault_addr(fault_addr), .inst_mem(inst_mem), .csr_rw(csr_rw),
    .csr_rw_addr(csr_rw_addr), .csr_wsc_mode(csr_wsc_mode),
    .csr_w_imm_mux(csr_w_imm_mux), .csr_w_data_reg(csr_w_data_reg),
    .csr_w_data_imm(csr_w_data_imm), .csr_r_data_out(csr_r_data_out),
    .PC_redirect(PC_redirect), .redirect_mux(redirect_mux),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
    .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
    .RegWrite_cancel(RegWrite_cancel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {FD, DE, EM, MW, RegWrite_cancel}
  function automatic logic [31:0] flushes();
    return {27'b0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, RegWrite_cancel};
  endfunction

  task automatic idle_inputs();
    exp_vector = 2'b00; mret = 1'b0; l_access_fault = 1'b0; s_access_fault = 1'b0;
    interrupt = 1'b0; csr_rw = 1'b0; csr_rw_addr = 12'h0; csr_wsc_mode = 2'b00;
    csr_w_imm_mux = 1'b0; csr_w_data_reg = 32'h0; csr_w_data_imm = 5'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // csrrs rd, csr, x0: reads without modifying.
  task automatic read_csr(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    csr_rw = 1'b1; csr_rw_addr = addr; csr_wsc_mode = 2'b10;
    csr_w_imm_mux = 1'b0; csr_w_data_reg = 32'h0;
    #1;
    chk(tag, csr_r_data_out, exp);
    csr_rw = 1'b0; csr_wsc_mode = 2'b00;
  endtask

  initial begin
    idle_inputs();
    epc_cur = 32'h0; epc_next = 32'h0; fault_addr = 32'h0; inst_mem = 32'h0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_redirect", {31'b0, redirect_mux}, 32'h0);
    chk("rst_flushes", flushes(), 32'h0);
    chk("rst_rdata", csr_r_data_out, 32'h0);
    rst_n = 1'b1;
    tick();
    read_csr(12'h305, 32'h0, "rst_mtvec");
    read_csr(12'h300, 32'h0, "rst_mstatus");
    read_csr(12'h342, 32'h0, "rst_mcause");

    // CSRRW mtvec <- 0x100
    csr_rw = 1'b1; csr_rw_addr = 12'h305; csr_wsc_mode = 2'b01; csr_w_data_reg = 32'h100;
    #1 chk("csrrw_old", csr_r_data_out, 32'h0);
    tick(); idle_inputs();
    read_csr(12'h305, 32'h100, "mtvec_written");

    // ecall at 0x40
    exp_vector = 2'b01; epc_cur = 32'h40;
    #1 chk("ecall_flush", flushes(), 32'h1F);
    chk("ecall_noredir", {31'b0, redirect_mux}, 32'h0);
    tick(); idle_inputs();
    chk("cause_redirect", {31'b0, redirect_mux}, 32'h1);
    chk("cause_pc", PC_redirect, 32'h100);
    chk("cause_flush", flushes(), 32'h10);
    tick();
    chk("back_idle", {31'b0, redirect_mux}, 32'h0);
    read_csr(12'h341, 32'h40, "ecall_mepc");
    read_csr(12'h342, 32'd11, "ecall_mcause");
    read_csr(12'h343, 32'h0, "ecall_mtval");

    // illegal and ecall together: illegal wins
    exp_vector = 2'b11; inst_mem = 32'hDEADBEEF; epc_cur = 32'h80;
    tick(); idle_inputs(); tick();
    read_csr(12'h342, 32'd2, "illegal_mcause");
    read_csr(12'h343, 32'hDEADBEEF, "illegal_mtval");

    // csrrsi mstatus, 8 -> MIE = 1
    csr_rw = 1'b1; csr_rw_addr = 12'h300; csr_wsc_mode = 2'b10;
    csr_w_imm_mux = 1'b1; csr_w_data_imm = 5'd8;
    tick(); idle_inputs();
    read_csr(12'h300, 32'h08, "mie_set");

    // Interrupt taken with return point epc_next
    interrupt = 1'b1; epc_next = 32'h48; epc_cur = 32'h44;
    #1 chk("irq_flush", flushes(), 32'h1F);
    tick();
    chk("irq_cause_pc", PC_redirect, 32'h100);
    tick();
    // Level still high but MIE is now 0
    chk("irq_masked_flush", flushes(), 32'h0);
    chk("irq_masked_redir", {31'b0, redirect_mux}, 32'h0);
    read_csr(12'h341, 32'h48, "irq_mepc");
    read_csr(12'h342, 32'h8000000B, "irq_mcause");
    read_csr(12'h300, 32'h80, "irq_mstatus");
    interrupt = 1'b0;

    // MRET
    mret = 1'b1;
    #1 chk("mret_redirect", {31'b0, redirect_mux}, 32'h1);
    chk("mret_pc", PC_redirect, 32'h48);
    chk("mret_flush", flushes(), 32'h18);
    tick(); idle_inputs();
    read_csr(12'h300, 32'h88, "mret_mstatus");

    // csrrs mstatus with a load fault in the same cycle: write dropped
    csr_rw = 1'b1; csr_rw_addr = 12'h300; csr_wsc_mode = 2'b10;
    csr_w_data_reg = 32'hFFFFFFFF; l_access_fault = 1'b1;
    fault_addr = 32'h1234; epc_cur = 32'h200;
    #1 chk("trap_rdata_zero", csr_r_data_out, 32'h0);
    chk("lfault_flush", flushes(), 32'h1F);
    tick(); idle_inputs(); tick();
    read_csr(12'h342, 32'd5, "lfault_mcause");
    read_csr(12'h343, 32'h1234, "lfault_mtval");
    read_csr(12'h300, 32'h80, "lfault_mstatus");

    // csrrc mepc
    csr_rw = 1'b1; csr_rw_addr = 12'h341; csr_wsc_mode = 2'b11; csr_w_data_reg = 32'h200;
    #1 chk("csrrc_old", csr_r_data_out, 32'h200);
    tick(); idle_inputs();
    read_csr(12'h341, 32'h0, "csrrc_mepc");

    // Unmapped CSR
    csr_rw = 1'b1; csr_rw_addr = 12'h7C0; csr_wsc_mode = 2'b01; csr_w_data_reg = 32'h55;
    tick(); idle_inputs();
    read_csr(12'h7C0, 32'h0, "unmapped");

    // Reset in the middle of trap entry
    exp_vector = 2'b01; epc_cur = 32'h300;
    tick(); idle_inputs();
    chk("pre_rst_redirect", {31'b0, redirect_mux}, 32'h1);
    rst_n = 1'b0;
    #1 chk("midrst_redirect", {31'b0, redirect_mux}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_redirect", {31'b0, redirect_mux}, 32'h0);
    read_csr(12'h342, 32'h0, "post_rst_mcause");
    read_csr(12'h341, 32'h0, "post_rst_mepc");
    read_csr(12'h305, 32'h0, "post_rst_mtvec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
